// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 9-bit adder between NREQ requesters.
// Grants in IDLE, adds in EXEC, holds the result in RESP until accepted.
module adder_9bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [9:0] sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module adder_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*9-1:0] req_a,
  input  logic [NREQ*9-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_sum,
  output logic [ID_W-1:0]   out_id,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [8:0]        a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic              out_valid_q;
  logic [9:0]        out_sum_q;
  logic [ID_W-1:0]   out_id_q;

  logic [2*NREQ-1:0] rot_valid;
  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [8:0]        a_sel, b_sel;
  logic [9:0]        add_sum;

  // (base + inc) mod NREQ without relying on NREQ being a power of two
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                               input int unsigned inc);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(inc);
    if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
    return s[ID_W-1:0];
  endfunction

  // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
  assign rot_valid = {req_valid, req_valid} >> rr_ptr_q;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot_valid[k]) begin
        found  = 1'b1;
        win_id = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_id == ID_W'(k)) begin
        a_sel = req_a[k*9 +: 9];
        b_sel = req_b[k*9 +: 9];
      end
    end
  end

  // Gated by rst_n so the grant reads zero while reset is held.
  assign req_ready = (rst_n && state_q == StIdle && found) ? (NREQ'(1) << win_id) : '0;

  adder_9bit u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            id_q    <= win_id;
            state_q <= StExec;
          end
        end
        StExec: begin
          out_sum_q   <= add_sum;
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= wrap_inc(out_id_q, 1);
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares a single adder_9bit instance between NREQ independent requesters.
- Each requester presents a 9-bit operand pair with a valid/ready handshake.
- A round-robin arbiter grants one request at a time, and a 3-state FSM sequences operand capture, add, and response.
- Results return on one shared 10-bit output with the requester ID and a valid/ready handshake. The block sits between operand producers and the shared add resource.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester ID; must equal ceil(log2(NREQ)), so 3 when NREQ is 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair pending.
- req_a  input  NREQ*9  operand A of requester i in bits [9i+8:9i].
- req_b  input  NREQ*9  operand B of requester i in bits [9i+8:9i].
- req_ready  output  NREQ  one-hot (or zero) grant/accept; bit i high accepts requester i this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  10  sum a+b, zero-extended and unsigned; bit 9 is carry.
- out_id  output  ID_W  index of the requester that produced out_sum.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - state=IDLE, rr_ptr=0, out_valid=0, out_sum=0, out_id=0, busy=0, req_ready=0, operand registers=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searched in order rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is combinational: only bit[winner] is high, and only in IDLE. It is all-zero if no req_valid is high.
  - On a handshake (req_valid[w] & req_ready[w]): latch req_a[w], req_b[w] and w into internal registers, then go to EXEC.
- EXEC (exactly 1 cycle):
  - The adder_9bit instance sees the latched operands.
  - Its 10-bit result is registered into out_sum; w is registered into out_id.
  - out_valid is set to 1 and the FSM goes to RESP.
- RESP:
  - out_valid=1; out_sum and out_id are held stable until accepted.
  - On out_valid & out_ready: out_valid clears next edge, rr_ptr=(out_id+1) mod NREQ, and the FSM goes to IDLE.
  - If out_ready stays low, the FSM stays in RESP indefinitely. req_ready stays 0, and new requests are not accepted or lost.
- Latency and throughput:
  - Request handshake at edge N gives out_valid high after edge N+2 (first observable in cycle N+2).
  - With out_ready tied high, one result every 3 cycles (IDLE→EXEC→RESP→IDLE).
- Fairness:
  - After requester k is served, requester k has the lowest priority for the next grant.
  - No requester waits more than NREQ-1 grants while holding req_valid.
- Arithmetic:
  - out_sum = {1'b0,a}+{1'b0,b}, full 10 bits; no overflow is possible.
  - 0x1FF+0x1FF = 0x3FE.
- Requester protocol:
  - A requester that drops req_valid before it is granted is simply skipped; the arbiter stores no request state.
  - req_a/req_b are sampled only on the handshake edge; later changes do not affect the in-flight operation.
- Simultaneous events:
  - out_ready high during EXEC has no effect; out_valid is not yet set.
  - The accept in RESP and new req_valid in the same cycle: a new grant occurs only in the following IDLE cycle.
- Reset mid-operation (EXEC or RESP):
  - Aborts immediately; all outputs return to reset values and rr_ptr=0.
  - The in-flight result is discarded and no out_valid is emitted for it.
- busy=1 exactly in EXEC and RESP.

Test Plan:
- Single request: req_valid=4'b0001, a=9'd100, b=9'd55, out_ready=1.
  - Expect req_ready=4'b0001 in the same cycle.
  - Expect out_valid after 2 edges with out_sum=10'd155 and out_id=0; busy high for 2 cycles.
- Carry/boundary: a=9'h1FF, b=9'h1FF from requester 2 → out_sum=10'h3FE, out_id=2. Then a=0, b=0 → out_sum=0.
- Round-robin: all four req_valid held high, out_ready=1.
  - Grant order 0,1,2,3,0,1; one out_valid every 3 cycles; out_id sequence matches.
- Back-pressure: out_ready=0 for 5 cycles after out_valid rises.
  - out_sum/out_id stay stable; req_ready=0 throughout.
  - Raise out_ready → accepted; the next grant goes to (id+1) mod NREQ.
- Sparse/skip: after serving requester 1, only req_valid[0] and req_valid[3] are high → grant 3, then 0.
  - Requester 2 asserts then drops req_valid before its turn → it is never granted.
- Reset mid-op: assert rst_n=0 asynchronously during RESP.
  - Outputs go to 0 immediately (out_valid=0, busy=0).
  - After release with req_valid=4'b1010, the first grant is requester 1 (rr_ptr=0).
